// File: rtl/alu_pkg.sv
// Shared ALU encodings: aluop values, main-decoder ctl codes and the funct3 values
// the execute stage understands.
package alu_pkg;

  localparam int XLEN  = 64;
  localparam int RD_W  = 5;
  localparam int CNT_W = 32;

  localparam logic [3:0] ALUOP_AND = 4'b0000;
  localparam logic [3:0] ALUOP_OR  = 4'b0001;
  localparam logic [3:0] ALUOP_ADD = 4'b0010;
  localparam logic [3:0] ALUOP_SUB = 4'b0110;
  localparam logic [3:0] ALUOP_ILL = 4'b1111;

  localparam logic [1:0] ALU_CTL_ADD   = 2'b00;
  localparam logic [1:0] ALU_CTL_SUB   = 2'b01;
  localparam logic [1:0] ALU_CTL_RTYPE = 2'b10;
  localparam logic [1:0] ALU_CTL_ILL   = 2'b11;

  localparam logic [2:0] FUNCT3_ADDSUB = 3'b000;
  localparam logic [2:0] FUNCT3_OR     = 3'b110;
  localparam logic [2:0] FUNCT3_AND    = 3'b111;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational ALU-control decode: main-decoder ctl plus funct fields -> aluop.
// Anything not recognised maps to ALUOP_ILL with illegal raised.
module alu_ctl_decode
  import alu_pkg::*;
(
  input  logic [1:0] ctl,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] aluop,
  output logic       illegal
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; a missed branch would infer a latch.
    aluop   = ALUOP_ILL;
    illegal = 1'b1;
    case (ctl)
      ALU_CTL_ADD: begin
        aluop   = ALUOP_ADD;
        illegal = 1'b0;
      end
      ALU_CTL_SUB: begin
        aluop   = ALUOP_SUB;
        illegal = 1'b0;
      end
      ALU_CTL_RTYPE: begin
        case (funct3)
          FUNCT3_AND: begin
            aluop   = ALUOP_AND;
            illegal = 1'b0;
          end
          FUNCT3_OR: begin
            aluop   = ALUOP_OR;
            illegal = 1'b0;
          end
          FUNCT3_ADDSUB: begin
            aluop   = funct7b5 ? ALUOP_SUB : ALUOP_ADD;
            illegal = 1'b0;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage front end: S1 holds the issued op and drives the external ALU,
// S2 captures its result for writeback. Valid/ready on both sides, sync flush.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN_P  = XLEN,
  parameter int RD_W_P  = RD_W,
  parameter int CNT_W_P = CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_ctl,
  input  logic [2:0]         in_funct3,
  input  logic               in_funct7b5,
  input  logic [XLEN_P-1:0]  in_op1,
  input  logic [XLEN_P-1:0]  in_op2,
  input  logic [RD_W_P-1:0]  in_rd,
  input  logic               in_branch,
  output logic [XLEN_P-1:0]  alu_op1,
  output logic [XLEN_P-1:0]  alu_op2,
  output logic [3:0]         alu_aluop,
  input  logic [XLEN_P-1:0]  alu_result,
  input  logic               alu_zero,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN_P-1:0]  out_result,
  output logic [RD_W_P-1:0]  out_rd,
  output logic               out_taken,
  output logic               out_illegal,
  output logic [CNT_W_P-1:0] retired_cnt
);

  logic [3:0] dec_aluop;
  logic       dec_illegal;

  alu_ctl_decode u_dec (
    .ctl      (in_ctl),
    .funct3   (in_funct3),
    .funct7b5 (in_funct7b5),
    .aluop    (dec_aluop),
    .illegal  (dec_illegal)
  );

  logic               s1_valid_q,   s1_valid_d;
  logic [XLEN_P-1:0]  s1_op1_q,     s1_op1_d;
  logic [XLEN_P-1:0]  s1_op2_q,     s1_op2_d;
  logic [3:0]         s1_aluop_q,   s1_aluop_d;
  logic [RD_W_P-1:0]  s1_rd_q,      s1_rd_d;
  logic               s1_branch_q,  s1_branch_d;
  logic               s1_illegal_q, s1_illegal_d;

  logic               s2_valid_q,   s2_valid_d;
  logic [XLEN_P-1:0]  s2_result_q,  s2_result_d;
  logic [RD_W_P-1:0]  s2_rd_q,      s2_rd_d;
  logic               s2_taken_q,   s2_taken_d;
  logic               s2_illegal_q, s2_illegal_d;

  logic [CNT_W_P-1:0] retired_cnt_q, retired_cnt_d;

  logic s2_adv, s1_adv, accept, s1_move, out_hs;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign accept   = in_valid && s1_adv;
  assign s1_move  = s1_valid_q && s2_adv;
  assign out_hs   = s2_valid_q && out_ready;

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_op1_d      = s1_op1_q;
    s1_op2_d      = s1_op2_q;
    s1_aluop_d    = s1_aluop_q;
    s1_rd_d       = s1_rd_q;
    s1_branch_d   = s1_branch_q;
    s1_illegal_d  = s1_illegal_q;
    s2_valid_d    = s2_valid_q;
    s2_result_d   = s2_result_q;
    s2_rd_d       = s2_rd_q;
    s2_taken_d    = s2_taken_q;
    s2_illegal_d  = s2_illegal_q;
    retired_cnt_d = retired_cnt_q;

    if (accept) begin
      s1_valid_d   = 1'b1;
      s1_op1_d     = in_op1;
      s1_op2_d     = in_op2;
      s1_aluop_d   = dec_aluop;
      s1_rd_d      = in_rd;
      s1_branch_d  = in_branch;
      s1_illegal_d = dec_illegal;
    end else if (s1_move) begin
      s1_valid_d   = 1'b0;
    end

    if (s1_move) begin
      s2_valid_d   = 1'b1;
      s2_result_d  = alu_result;
      s2_rd_d      = s1_rd_q;
      s2_taken_d   = s1_branch_q && alu_zero;
      s2_illegal_d = s1_illegal_q;
    end else if (out_hs) begin
      s2_valid_d   = 1'b0;
    end

    // Flush only clears the valids; stale data is never observed without a valid.
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end

    if (out_hs && (retired_cnt_q != '1)) begin
      retired_cnt_d = retired_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_op1_q      <= '0;
      s1_op2_q      <= '0;
      s1_aluop_q    <= '0;
      s1_rd_q       <= '0;
      s1_branch_q   <= 1'b0;
      s1_illegal_q  <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_result_q   <= '0;
      s2_rd_q       <= '0;
      s2_taken_q    <= 1'b0;
      s2_illegal_q  <= 1'b0;
      retired_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values, independent of statement order.
      s1_valid_q    <= s1_valid_d;
      s1_op1_q      <= s1_op1_d;
      s1_op2_q      <= s1_op2_d;
      s1_aluop_q    <= s1_aluop_d;
      s1_rd_q       <= s1_rd_d;
      s1_branch_q   <= s1_branch_d;
      s1_illegal_q  <= s1_illegal_d;
      s2_valid_q    <= s2_valid_d;
      s2_result_q   <= s2_result_d;
      s2_rd_q       <= s2_rd_d;
      s2_taken_q    <= s2_taken_d;
      s2_illegal_q  <= s2_illegal_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign in_ready    = s1_adv;
  assign alu_op1     = s1_op1_q;
  assign alu_op2     = s1_op2_q;
  assign alu_aluop   = s1_aluop_q;
  assign out_valid   = s2_valid_q;
  assign out_result  = s2_result_q;
  assign out_rd      = s2_rd_q;
  assign out_taken   = s2_taken_q;
  assign out_illegal = s2_illegal_q;
  assign retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU closes the loop, and an in-order
// queue of accepted ops (with their age in cycles) predicts every output.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_ctl = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_funct7b5 = 1'b0;
  logic [63:0] in_op1 = '0;
  logic [63:0] in_op2 = '0;
  logic [4:0]  in_rd = '0;
  logic        in_branch = 1'b0;
  logic [63:0] alu_op1, alu_op2, alu_result;
  logic [3:0]  alu_aluop;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic        out_taken, out_illegal;
  logic [31:0] retired_cnt;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctl(in_ctl), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_op1(in_op1), .in_op2(in_op2), .in_rd(in_rd), .in_branch(in_branch),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_aluop(alu_aluop),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_taken(out_taken),
    .out_illegal(out_illegal), .retired_cnt(retired_cnt)
  );

  // Behavioural ALU standing in for the real one outside the block.
  always_comb begin
    case (alu_aluop)
      4'b0000: alu_result = alu_op1 & alu_op2;
      4'b0001: alu_result = alu_op1 | alu_op2;
      4'b0010: alu_result = alu_op1 + alu_op2;
      4'b0110: alu_result = alu_op1 - alu_op2;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  typedef struct {
    logic [63:0] op1, op2, res;
    logic [3:0]  aluop;
    logic [4:0]  rd;
    logic        taken, ill;
    int          age;
  } ent_t;

  ent_t        q[$];
  logic [31:0] exp_cnt;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t ref_eval(input logic [1:0] ctl, input logic [2:0] f3, input logic b5,
                                    input logic [63:0] a, input logic [63:0] b,
                                    input logic [4:0] rd, input logic br);
    ent_t e;
    e.op1 = a; e.op2 = b; e.rd = rd; e.age = 0;
    e.res = '0; e.aluop = 4'b1111; e.ill = 1'b1;
    if (ctl == 2'b00) begin
      e.res = a + b; e.aluop = 4'b0010; e.ill = 1'b0;
    end else if (ctl == 2'b01) begin
      e.res = a - b; e.aluop = 4'b0110; e.ill = 1'b0;
    end else if (ctl == 2'b10) begin
      if (f3 == 3'b111) begin
        e.res = a & b; e.aluop = 4'b0000; e.ill = 1'b0;
      end else if (f3 == 3'b110) begin
        e.res = a | b; e.aluop = 4'b0001; e.ill = 1'b0;
      end else if (f3 == 3'b000) begin
        e.res = b5 ? a - b : a + b; e.aluop = b5 ? 4'b0110 : 4'b0010; e.ill = 1'b0;
      end
    end
    e.taken = br && (e.res == '0);
    return e;
  endfunction

  function automatic logic head_visible();
    return (q.size() > 0) && (q[0].age >= 1);
  endfunction

  task automatic check_outputs();
    logic   vis;
    ent_t   t;
    vis = head_visible();
    check("out_valid", out_valid, vis);
    if (vis) begin
      check("out_result", out_result, q[0].res);
      check("out_rd", out_rd, q[0].rd);
      check("out_taken", out_taken, q[0].taken);
      check("out_illegal", out_illegal, q[0].ill);
    end
    check("retired_cnt", retired_cnt, exp_cnt);
    // The youngest op sits in S1 either behind a stalled S2 or right after it was accepted.
    if ((q.size() == 2) || (q.size() == 1 && q[0].age == 0)) begin
      t = q[q.size()-1];
      check("alu_op1", alu_op1, t.op1);
      check("alu_op2", alu_op2, t.op2);
      check("alu_aluop", alu_aluop, t.aluop);
    end
  endtask

  // Called just after a falling edge; returns after the next falling edge with outputs checked.
  task automatic step(input logic v, input logic fl, input logic ordy, output logic acc);
    logic exp_rdy, hs;
    ent_t e;
    in_valid = v; flush = fl; out_ready = ordy;
    #1;
    exp_rdy = (q.size() < 2) || ordy;
    check("in_ready", in_ready, exp_rdy);
    hs  = head_visible() && ordy;
    acc = v && exp_rdy && !fl;
    e   = ref_eval(in_ctl, in_funct3, in_funct7b5, in_op1, in_op2, in_rd, in_branch);
    @(posedge clk);
    if (hs) begin
      void'(q.pop_front());
      if (exp_cnt != '1) exp_cnt++;
    end
    if (fl) q.delete();
    foreach (q[i]) q[i].age++;
    if (acc) q.push_back(e);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_op(input logic [1:0] ctl, input logic [2:0] f3, input logic b5,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rd, input logic br);
    in_ctl = ctl; in_funct3 = f3; in_funct7b5 = b5;
    in_op1 = a; in_op2 = b; in_rd = rd; in_branch = br;
  endtask

  task automatic rand_op();
    logic [2:0] f3;
    f3 = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 3) != 0) begin
      case ($urandom_range(0, 2))
        0: f3 = 3'b000;
        1: f3 = 3'b110;
        default: f3 = 3'b111;
      endcase
    end
    set_op(2'($urandom_range(0, 3)), f3, 1'($urandom_range(0, 1)),
           {$urandom, $urandom}, {$urandom, $urandom},
           5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    if ($urandom_range(0, 3) == 0) in_op2 = in_op1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete();
    exp_cnt = '0;
  endtask

  // Issue one op with writeback ready, then idle one cycle so it lands in S2.
  task automatic issue_and_land(input logic [1:0] ctl, input logic [2:0] f3, input logic b5,
                                input logic [63:0] a, input logic [63:0] b,
                                input logic [4:0] rd, input logic br);
    logic acc;
    set_op(ctl, f3, b5, a, b, rd, br);
    step(1'b1, 1'b0, 1'b1, acc);
    check("lat_not_yet", out_valid, 1'b0);
    step(1'b0, 1'b0, 1'b1, acc);
  endtask

  initial begin
    logic acc;
    int   sent;
    int   cyc;
    logic saw_stall;

    exp_cnt = '0;
    do_reset();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_alu_op1", alu_op1, 64'd0);
    check("rst_alu_aluop", alu_aluop, 4'd0);
    check("rst_retired", retired_cnt, 32'd0);
    check("rst_out_result", out_result, 64'd0);

    issue_and_land(2'b00, 3'b000, 1'b0, 64'd5, 64'd7, 5'd3, 1'b0);
    check("add_valid", out_valid, 1'b1);
    check("add_res", out_result, 64'd12);
    check("add_rd", out_rd, 5'd3);

    issue_and_land(2'b01, 3'b000, 1'b0, 64'h10, 64'h10, 5'd1, 1'b1);
    check("beq_eq_taken", out_taken, 1'b1);
    check("beq_eq_res", out_result, 64'd0);
    issue_and_land(2'b01, 3'b000, 1'b0, 64'h10, 64'h11, 5'd1, 1'b1);
    check("beq_ne_taken", out_taken, 1'b0);
    check("beq_ne_res", out_result, 64'hFFFF_FFFF_FFFF_FFFF);

    issue_and_land(2'b10, 3'b111, 1'b0, 64'hF0F0, 64'hFF00, 5'd4, 1'b0);
    check("and_res", out_result, 64'hF000);
    issue_and_land(2'b10, 3'b110, 1'b0, 64'hF0F0, 64'hFF00, 5'd5, 1'b0);
    check("or_res", out_result, 64'hFFF0);
    issue_and_land(2'b10, 3'b001, 1'b0, 64'hF0F0, 64'hFF00, 5'd6, 1'b0);
    check("ill_flag", out_illegal, 1'b1);
    check("ill_res", out_result, 64'd0);
    issue_and_land(2'b00, 3'b000, 1'b0, 64'd1, 64'd2, 5'd7, 1'b1);
    check("nobr_taken", out_taken, 1'b0);
    step(1'b0, 1'b0, 1'b1, acc);

    // Eight-op stream with writeback stalled on cycles 3..6.
    do_reset();
    sent = 0;
    saw_stall = 1'b0;
    cyc = 0;
    while ((retired_cnt != 32'd8 || exp_cnt != 32'd8) && cyc < 40) begin
      rand_op();
      in_rd = 5'(sent);
      #1;
      if (!in_ready) saw_stall = 1'b1;
      step(sent < 8, 1'b0, !(cyc >= 3 && cyc <= 6), acc);
      if (acc) sent++;
      cyc++;
    end
    check("stream_retired", retired_cnt, 32'd8);
    check("stream_stalled", saw_stall, 1'b1);
    check("stream_budget", (cyc < 40), 1'b1);

    // Flush with both stages full and a new op offered in the same cycle.
    do_reset();
    rand_op();
    step(1'b1, 1'b0, 1'b0, acc);
    rand_op();
    step(1'b1, 1'b0, 1'b0, acc);
    check("flush_pre_valid", out_valid, 1'b1);
    out_ready = 1'b0;
    #1;
    check("flush_pre_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    rand_op();
    step(1'b1, 1'b1, 1'b0, acc);
    check("flush_valid", out_valid, 1'b0);
    step(1'b0, 1'b0, 1'b1, acc);
    check("flush_no_accept", out_valid, 1'b0);
    check("flush_retired", retired_cnt, 32'd0);

    // Asynchronous reset pulse between edges while ops are in flight.
    for (int i = 0; i < 4; i++) begin
      rand_op();
      step(1'b1, 1'b0, 1'b1, acc);
    end
    check("arst_pre_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_retired", retired_cnt, 32'd0);
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_aluop", alu_aluop, 4'd0);
    #1 rst = 1'b0;
    q.delete();
    exp_cnt = '0;
    @(negedge clk);
    check_outputs();

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      rand_op();
      step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, acc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
